sync_fifo_prog: RTL and testbench

Parametrised single-clock FIFO; next generation of the team's basic synchronous FIFO. Adds any-depth support (non-power-of-2), selectable standard/first-word-fall-through read mode, and runtime-programmable almost-full/almost-empty levels. Adds a synchronous flush, an occupancy output, and well-defined simultaneous read/write at full and empty. Sits between producer/consumer stages as the general-purpose buffer for datapath and UVM-verified subsystems.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_ram.sv | 26 ++
 rtl/sync_fifo_prog.sv | 133 +++++++++++++
 tb/tb_sync_fifo_prog.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared encodings and helpers for the programmable synchronous FIFO.
// Pointer arithmetic lives here so RAM and control agree on wrap behaviour.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Registered one-cycle status pulses reported back to the producer/consumer.
    typedef struct packed {
        logic wr_ack;
        logic overflow;
        logic underflow;
    } fifo_stat_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Wrap by compare so non power-of-two depths only ever index real entries.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DATA_W x DEPTH storage array: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module fifo_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with any depth, standard or first-word-fall-through read,
// programmable almost-full/almost-empty levels, synchronous flush and occupancy.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 8,
    parameter  int FWFT   = FIFO_STD,
    localparam int CNT_W  = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    input  logic [CNT_W-1:0]  af_level,
    input  logic [CNT_W-1:0]  ae_level,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              wr_ack,
    output logic              overflow,
    output logic              underflow,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count
);

    localparam int              PTR_W   = ptr_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_nxt;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] rd_data;
    logic              rd_acc;
    logic              wr_acc;
    fifo_stat_t        stat_q;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Flush suppresses both accesses so nothing moves in the flush cycle.
    assign rd_acc = rd_en & ~empty & ~flush;
    assign wr_acc = wr_en & (~full | rd_acc) & ~flush;

    assign wr_ptr_nxt = PTR_W'(ptr_inc(int'(wr_ptr), DEPTH));
    assign rd_ptr_nxt = PTR_W'(ptr_inc(int'(rd_ptr), DEPTH));

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            stat_q  <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            stat_q  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr_nxt;
            end
            if (wr_acc && !rd_acc) begin
                count_q <= count_q + CNT_W'(1);
            end else if (rd_acc && !wr_acc) begin
                count_q <= count_q - CNT_W'(1);
            end
            stat_q.wr_ack    <= wr_acc;
            stat_q.overflow  <= wr_en & ~wr_acc;
            stat_q.underflow <= rd_en & ~rd_acc;
        end
    end

    assign wr_ack    = stat_q.wr_ack;
    assign overflow  = stat_q.overflow;
    assign underflow = stat_q.underflow;
    assign count     = count_q;

    // Levels are live inputs; the degenerate settings pin the flags high.
    assign almost_full  = (af_level == '0) | (count_q >= af_level);
    assign almost_empty = (ae_level >= DEPTH_C) | (count_q <= ae_level);

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            // Gate the head while empty so an unwritten slot never reaches the port.
            assign data_out = empty ? '0 : rd_data;
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [DATA_W-1:0] dout_q;
            logic              valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= rd_data;
                    end
                end
            end

            assign data_out = dout_q;
            assign rd_valid = valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: three configurations driven side by side and
// compared every cycle against a queue-based model, plus directed literal checks.
module tb_sync_fifo_prog;

    localparam int N = 3;

    function automatic int depth_of(input int k);
        case (k)
            0:       return 5;
            1:       return 8;
            default: return 6;
        endcase
    endfunction

    function automatic int fwft_of(input int k);
        return (k == 2) ? 1 : 0;
    endfunction

    logic clk = 1'b0;
    logic rst_n;
    bit   chk_en = 1'b0;

    logic        wen_i [N];
    logic        ren_i [N];
    logic        fl_i  [N];
    logic [15:0] din_i [N];
    int          af_i  [N];
    int          ae_i  [N];

    logic [15:0] dout_a [N];
    logic        rv_a [N], wa_a [N], ov_a [N], ud_a [N];
    logic        fu_a [N], em_a [N], afl_a [N], ael_a [N];
    int          cnt_a [N];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < N; k++) begin : g_dut
        localparam int D  = depth_of(k);
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] af_v, ae_v, cnt_v;
        logic [15:0]   dout_v;
        logic          rv_v, wa_v, ov_v, ud_v, fu_v, em_v, afl_v, ael_v;

        assign af_v = CW'(af_i[k]);
        assign ae_v = CW'(ae_i[k]);

        sync_fifo_prog #(
            .DATA_W (16),
            .DEPTH  (D),
            .FWFT   (fwft_of(k))
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .flush        (fl_i[k]),
            .wr_en        (wen_i[k]),
            .data_in      (din_i[k]),
            .rd_en        (ren_i[k]),
            .af_level     (af_v),
            .ae_level     (ae_v),
            .data_out     (dout_v),
            .rd_valid     (rv_v),
            .wr_ack       (wa_v),
            .overflow     (ov_v),
            .underflow    (ud_v),
            .full         (fu_v),
            .empty        (em_v),
            .almost_full  (afl_v),
            .almost_empty (ael_v),
            .count        (cnt_v)
        );

        assign dout_a[k] = dout_v;
        assign rv_a[k]   = rv_v;
        assign wa_a[k]   = wa_v;
        assign ov_a[k]   = ov_v;
        assign ud_a[k]   = ud_v;
        assign fu_a[k]   = fu_v;
        assign em_a[k]   = em_v;
        assign afl_a[k]  = afl_v;
        assign ael_a[k]  = ael_v;
        assign cnt_a[k]  = int'(cnt_v);
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    // Reference model: contents as a queue, registered outputs as plain variables.
    int          q [N][$];
    logic [15:0] m_dout [N];
    bit          m_rv [N], m_wa [N], m_ov [N], m_ud [N];

    always @(posedge clk or negedge rst_n) begin
        int sz;
        bit racc, wacc;
        for (int k = 0; k < N; k++) begin
            if (!rst_n) begin
                q[k].delete();
                m_dout[k] = '0;
                m_rv[k] = 0; m_wa[k] = 0; m_ov[k] = 0; m_ud[k] = 0;
            end else if (fl_i[k]) begin
                q[k].delete();
                m_rv[k] = 0; m_wa[k] = 0; m_ov[k] = 0; m_ud[k] = 0;
            end else begin
                sz   = q[k].size();
                racc = ren_i[k] && (sz > 0);
                wacc = wen_i[k] && ((sz < depth_of(k)) || racc);
                if (racc) m_dout[k] = 16'(q[k].pop_front());
                if (wacc) q[k].push_back(int'(din_i[k]));
                m_rv[k] = racc;
                m_wa[k] = wacc;
                m_ov[k] = wen_i[k] && !wacc;
                m_ud[k] = ren_i[k] && !racc;
            end
        end
    end

    always @(negedge clk) begin
        int sz;
        if (chk_en) begin
            for (int k = 0; k < N; k++) begin
                sz = q[k].size();
                chk("count", k, cnt_a[k], sz);
                chk("full", k, fu_a[k], sz == depth_of(k));
                chk("empty", k, em_a[k], sz == 0);
                chk("almost_full", k, afl_a[k], sz >= af_i[k]);
                chk("almost_empty", k, ael_a[k], sz <= ae_i[k]);
                chk("wr_ack", k, wa_a[k], m_wa[k]);
                chk("overflow", k, ov_a[k], m_ov[k]);
                chk("underflow", k, ud_a[k], m_ud[k]);
                if (fwft_of(k) == 1) begin
                    chk("rd_valid", k, rv_a[k], sz > 0);
                    chk("data_out", k, dout_a[k], (sz > 0) ? 32'(q[k][0]) : 32'd0);
                end else begin
                    chk("rd_valid", k, rv_a[k], m_rv[k]);
                    chk("data_out", k, dout_a[k], m_dout[k]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < N; k++) begin
            wen_i[k] = 0; ren_i[k] = 0; fl_i[k] = 0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        for (int k = 0; k < N; k++) din_i[k] = '0;
        af_i[0] = 4; ae_i[0] = 1;
        af_i[1] = 3; ae_i[1] = 1;
        af_i[2] = 5; ae_i[2] = 2;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 0, cnt_a[0], 0);
        chk("rst_empty", 0, em_a[0], 1);
        chk("rst_rd_valid", 0, rv_a[0], 0);
        chk("rst_data_out", 0, dout_a[0], 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Fill depth-5 FIFO, then overflow it.
        for (int i = 0; i < 5; i++) begin
            wen_i[0] = 1; din_i[0] = 16'(32'hA1 + i);
            step();
        end
        chk("fill_count", 0, cnt_a[0], 5);
        chk("fill_full", 0, fu_a[0], 1);
        din_i[0] = 16'hA6;
        step();
        wen_i[0] = 0;
        chk("ovf_flag", 0, ov_a[0], 1);
        chk("ovf_ack", 0, wa_a[0], 0);
        for (int i = 0; i < 5; i++) begin
            ren_i[0] = 1;
            step();
            chk("drain_data", 0, dout_a[0], 32'hA1 + i);
            chk("drain_valid", 0, rv_a[0], 1);
        end
        ren_i[0] = 0;
        step();
        chk("drain_empty", 0, em_a[0], 1);

        // Pointer wrap: write 3, read 3, write 5, read 5.
        for (int i = 0; i < 3; i++) begin wen_i[0] = 1; din_i[0] = 16'(32'hC0 + i); step(); end
        wen_i[0] = 0;
        ren_i[0] = 1; repeat (3) step(); ren_i[0] = 0;
        chk("wrap_mid", 0, dout_a[0], 32'hC2);
        for (int i = 0; i < 5; i++) begin wen_i[0] = 1; din_i[0] = 16'(32'hD0 + i); step(); end
        wen_i[0] = 0;
        for (int i = 0; i < 5; i++) begin
            ren_i[0] = 1;
            step();
            chk("wrap_data", 0, dout_a[0], 32'hD0 + i);
            chk("wrap_underflow", 0, ud_a[0], 0);
        end
        ren_i[0] = 0;
        chk("wrap_empty", 0, em_a[0], 1);

        // Simultaneous read/write while full.
        for (int i = 0; i < 5; i++) begin wen_i[0] = 1; din_i[0] = 16'(32'hE0 + i); step(); end
        ren_i[0] = 1; din_i[0] = 16'h55;
        step();
        wen_i[0] = 0;
        chk("fullrw_count", 0, cnt_a[0], 5);
        chk("fullrw_ack", 0, wa_a[0], 1);
        chk("fullrw_ovf", 0, ov_a[0], 0);
        chk("fullrw_data", 0, dout_a[0], 32'hE0);
        repeat (5) step();
        ren_i[0] = 0;
        chk("fullrw_last", 0, dout_a[0], 32'h55);

        // Simultaneous read/write while empty.
        wen_i[0] = 1; ren_i[0] = 1; din_i[0] = 16'h77;
        step();
        wen_i[0] = 0;
        chk("emptyrw_udf", 0, ud_a[0], 1);
        chk("emptyrw_ack", 0, wa_a[0], 1);
        chk("emptyrw_count", 0, cnt_a[0], 1);
        chk("emptyrw_valid", 0, rv_a[0], 0);
        step();
        ren_i[0] = 0;
        chk("emptyrw_data", 0, dout_a[0], 32'h77);
        chk("emptyrw_valid2", 0, rv_a[0], 1);

        // First-word-fall-through head visibility.
        wen_i[2] = 1; din_i[2] = 16'h1234;
        step();
        wen_i[2] = 0;
        chk("fwft_valid", 2, rv_a[2], 1);
        chk("fwft_data", 2, dout_a[2], 32'h1234);
        ren_i[2] = 1;
        step();
        ren_i[2] = 0;
        chk("fwft_pop_valid", 2, rv_a[2], 0);

        // Almost flags with af=3, ae=1 on the depth-8 FIFO, then flush.
        for (int n = 0; n <= 4; n++) begin
            chk("lvl_count", 1, cnt_a[1], n);
            chk("lvl_ae", 1, ael_a[1], n <= 1);
            chk("lvl_af", 1, afl_a[1], n >= 3);
            if (n < 4) begin
                wen_i[1] = 1; din_i[1] = 16'(32'h300 + n);
                step();
                wen_i[1] = 0;
            end
        end
        fl_i[1] = 1;
        step();
        fl_i[1] = 0;
        chk("flush_count", 1, cnt_a[1], 0);
        chk("flush_empty", 1, em_a[1], 1);

        // Asynchronous reset in the middle of a write burst.
        for (int k = 0; k < N; k++) begin wen_i[k] = 1; din_i[k] = 16'hBEEF; end
        step();
        step();
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            chk("arst_count", k, cnt_a[k], 0);
            chk("arst_valid", k, rv_a[k], 0);
            chk("arst_ack", k, wa_a[k], 0);
            chk("arst_data", k, dout_a[k], 0);
        end
        idle_all();
        step();
        rst_n = 1'b1;

        // Randomised traffic on all three FIFOs with drifting fill bias.
        begin
            int wb [N];
            int rb [N];
            for (int cyc = 0; cyc < 4000; cyc++) begin
                if (cyc % 200 == 0) begin
                    for (int k = 0; k < N; k++) begin
                        wb[k] = 20 + int'($urandom_range(0, 60));
                        rb[k] = 20 + int'($urandom_range(0, 60));
                    end
                end
                for (int k = 0; k < N; k++) begin
                    wen_i[k] = ($urandom_range(0, 99) < wb[k]);
                    ren_i[k] = ($urandom_range(0, 99) < rb[k]);
                    fl_i[k]  = ($urandom_range(0, 63) == 0);
                    din_i[k] = 16'($urandom);
                    if (cyc % 37 == 0) begin
                        af_i[k] = int'($urandom_range(0, depth_of(k) + 1));
                        ae_i[k] = int'($urandom_range(0, depth_of(k) + 1));
                    end
                end
                if (cyc == 2500) begin
                    #2 rst_n = 1'b0;
                    step();
                    rst_n = 1'b1;
                end else begin
                    step();
                end
            end
        end
        idle_all();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
